// File: rtl/hash_nearest.sv
// Greedy nearest-neighbour search: reads a reference 256-bit hash, then every unvisited candidate, returns the min Hamming distance.
// Latency 10 + 10*evaluated + skipped cycles from start to done; start/init_visited are ignored while busy.
module hash_nearest #(
    parameter int MAX_IMAGES = 32,
    parameter int HASH_BASE  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_visited,
    input  logic        start,
    input  logic [8:0]  ref_index,
    input  logic [8:0]  num_images,
    output logic        busy,
    output logic        done,
    output logic [8:0]  best_index,
    output logic [8:0]  best_dist,
    output logic        none_left,
    output logic [11:0] dist_A,
    input  logic [31:0] dist_O,
    output logic        dist_WEB
);

    localparam logic [8:0] NO_DIST = 9'd511;

    typedef enum logic [2:0] {IDLE, LOAD_REF, SCAN, CMP, DONE} state_t;

    state_t                  state, state_nxt;
    logic [8:0]              ref_q, num_q, cand, run_dist, run_idx, acc;
    logic [3:0]              word_cnt;
    logic [255:0]            ref_hash;
    logic [MAX_IMAGES-1:0]   visited;
    logic                    rd_vld, rd_ref, searched;
    logic [2:0]              rd_word;

    logic [8:0]              num_clamped, issue_idx, fin_dist, fin_idx;
    logic [2:0]              issue_word;
    logic                    reject, issue, cand_visited, cand_skip, cand_last;
    logic [31:0]             ref_word;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int b = 0; b < 32; b++) c = c + {5'd0, v[b]};
        return c;
    endfunction

    assign num_clamped = (num_images > 9'(MAX_IMAGES)) ? 9'(MAX_IMAGES) : num_images;
    assign reject      = (ref_index >= num_clamped);
    assign cand_last   = ((cand + 9'd1) == num_q);
    assign cand_skip   = (cand == ref_q) || cand_visited;
    assign ref_word    = ref_hash[{rd_word, 5'b0} +: 32];

    always_comb begin
        cand_visited = 1'b0;
        for (int i = 0; i < MAX_IMAGES; i++) begin
            if (cand == 9'(i)) cand_visited = visited[i];
        end
    end

    // Best result as it will stand once the current cycle retires.
    always_comb begin
        fin_dist = run_dist;
        fin_idx  = run_idx;
        if (state == IDLE) begin
            fin_dist = NO_DIST;
            fin_idx  = ref_index;
        end else if (state == CMP && acc < run_dist) begin
            fin_dist = acc;
            fin_idx  = cand;
        end
    end

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_idx  = ref_q;
        issue_word = word_cnt[2:0];
        case (state)
            IDLE: begin
                if (start) state_nxt = reject ? DONE : LOAD_REF;
            end
            LOAD_REF: begin
                if (!word_cnt[3]) issue = 1'b1;
                else              state_nxt = SCAN;
            end
            SCAN: begin
                if (word_cnt == 4'd0 && cand_skip) begin
                    state_nxt = cand_last ? DONE : SCAN;
                end else if (!word_cnt[3]) begin
                    issue     = 1'b1;
                    issue_idx = cand;
                end else begin
                    state_nxt = CMP;
                end
            end
            CMP:     state_nxt = cand_last ? DONE : SCAN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign dist_A   = issue ? (12'(HASH_BASE) + {issue_idx, issue_word}) : 12'd0;
    assign dist_WEB = 1'b1;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ref_q      <= '0;
            num_q      <= '0;
            cand       <= '0;
            run_dist   <= '0;
            run_idx    <= '0;
            acc        <= '0;
            word_cnt   <= '0;
            ref_hash   <= '0;
            visited    <= '0;
            rd_vld     <= 1'b0;
            rd_ref     <= 1'b0;
            rd_word    <= '0;
            searched   <= 1'b0;
            best_index <= '0;
            best_dist  <= '0;
            none_left  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_vld  <= issue;
            rd_ref  <= (state == LOAD_REF);
            rd_word <= issue_word;

            // Read data lags its address by one cycle.
            if (rd_vld) begin
                if (rd_ref) ref_hash[{rd_word, 5'b0} +: 32] <= dist_O;
                else        acc <= acc + {3'd0, popcount32(dist_O ^ ref_word)};
            end

            case (state)
                IDLE: begin
                    if (init_visited) visited <= '0;
                    if (start) begin
                        num_q    <= num_clamped;
                        searched <= !reject;
                        if (!reject) begin
                            ref_q    <= ref_index;
                            cand     <= '0;
                            run_dist <= NO_DIST;
                            run_idx  <= ref_index;
                            word_cnt <= '0;
                            acc      <= '0;
                        end
                    end
                end
                LOAD_REF: begin
                    word_cnt <= word_cnt[3] ? 4'd0 : word_cnt + 4'd1;
                end
                SCAN: begin
                    if (word_cnt == 4'd0 && cand_skip) cand <= cand + 9'd1;
                    else word_cnt <= word_cnt[3] ? 4'd0 : word_cnt + 4'd1;
                end
                CMP: begin
                    run_dist <= fin_dist;
                    run_idx  <= fin_idx;
                    acc      <= '0;
                    cand     <= cand + 9'd1;
                end
                DONE: begin
                    // Rejected starts never touch the chain.
                    for (int i = 0; i < MAX_IMAGES; i++) begin
                        if (searched && ref_q == 9'(i)) visited[i] <= 1'b1;
                        if (searched && !none_left && best_index == 9'(i)) visited[i] <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (state_nxt == DONE && state != DONE) begin
                best_index <= fin_idx;
                best_dist  <= fin_dist;
                none_left  <= (fin_dist == NO_DIST);
            end
        end
    end

endmodule

// File: tb/tb_hash_nearest.sv
// Directed bench for hash_nearest: chained searches, ties, exhaustion, rejected starts, clamping and mid-search reset.
module tb_hash_nearest;

    logic        clk = 1'b0;
    logic        reset, init_visited, start;
    logic [8:0]  ref_index, num_images;
    logic        busy, done, none_left, dist_WEB;
    logic [8:0]  best_index, best_dist;
    logic [11:0] dist_A;
    logic [31:0] dist_O;
    logic [31:0] mem [0:4095];

    int n_cmp = 0;
    int n_fail = 0;

    hash_nearest #(.MAX_IMAGES(32), .HASH_BASE(256)) dut (
        .clk(clk), .reset(reset), .init_visited(init_visited), .start(start),
        .ref_index(ref_index), .num_images(num_images), .busy(busy), .done(done),
        .best_index(best_index), .best_dist(best_dist), .none_left(none_left),
        .dist_A(dist_A), .dist_O(dist_O), .dist_WEB(dist_WEB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) dist_O <= mem[dist_A];

    typedef struct {
        logic init;
        int   ref_i;
        int   num;
        int   exp_cyc;
        int   exp_idx;
        int   exp_dist;
        int   exp_none;
        int   exp_rd;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_word(input int img, input int w, input logic [31:0] v);
        mem[256 + 8*img + w] = v;
    endtask

    task automatic run_search(input logic init, input int r, input int n,
                              output int cyc, output int rd_seen);
        @(negedge clk);
        start        = 1'b1;
        init_visited = init;
        ref_index    = r[8:0];
        num_images   = n[8:0];
        @(posedge clk); #1;
        start        = 1'b0;
        init_visited = 1'b0;
        cyc          = 1;
        rd_seen      = (dist_A != 12'd0) ? 1 : 0;
        while (!done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (dist_A != 12'd0) rd_seen = 1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: no done within %0d cycles", cyc);
        end
    endtask

    task automatic check_result(input string tag, input int cyc, input int ei, input int ed,
                                input int en, input int ec);
        chk({tag, "_cycle"}, cyc, ec);
        chk({tag, "_best_index"}, int'(best_index), ei);
        chk({tag, "_best_dist"}, int'(best_dist), ed);
        chk({tag, "_none_left"}, int'(none_left), en);
        @(posedge clk); #1;
        chk({tag, "_busy_fall"}, int'(busy), 0);
    endtask

    initial begin
        int cyc, rd, ndone;
        for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
        reset = 1'b1; init_visited = 1'b0; start = 1'b0;
        ref_index = '0; num_images = '0;

        // Scenario A: img0 = 0, img1 = 0xF in word 0, img2 = all ones, images 3.. zero.
        set_word(1, 0, 32'h0000_000F);
        for (int w = 0; w < 8; w++) set_word(2, w, 32'hFFFF_FFFF);

        vecs[0] = '{1'b1, 0,   3,   31, 1,  4,   0, 1};
        vecs[1] = '{1'b0, 1,   3,   22, 2,  252, 0, 1};
        vecs[2] = '{1'b0, 2,   3,   13, 2,  511, 1, 1};
        vecs[3] = '{1'b0, 5,   3,   1,  5,  511, 1, 0};
        vecs[4] = '{1'b0, 40,  100, 1,  40, 511, 1, 0};
        vecs[5] = '{1'b0, 20,  100, 294, 3, 0,   0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_best_index", int'(best_index), 0);
        chk("rst_best_dist", int'(best_dist), 0);
        chk("rst_none_left", int'(none_left), 0);
        chk("rst_dist_A", int'(dist_A), 0);
        chk("rst_dist_WEB", int'(dist_WEB), 1);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run_search(vecs[k].init, vecs[k].ref_i, vecs[k].num, cyc, rd);
            check_result($sformatf("vec%0d", k), cyc, vecs[k].exp_idx, vecs[k].exp_dist,
                         vecs[k].exp_none, vecs[k].exp_cyc);
            chk($sformatf("vec%0d_mem_read", k), rd, vecs[k].exp_rd);
        end

        // Tie: img1 and img2 both 7 bits away from img0; init arrives with start.
        set_word(1, 0, 32'h0000_007F);
        for (int w = 0; w < 8; w++) set_word(2, w, 32'h0);
        set_word(2, 3, 32'h0000_7F00);
        run_search(1'b1, 0, 3, cyc, rd);
        check_result("tie", cyc, 1, 7, 0, 31);
        run_search(1'b0, 1, 3, cyc, rd);
        check_result("tie_chain", cyc, 2, 14, 0, 22);

        // Reset in the middle of the scan of candidate 1.
        @(negedge clk);
        start = 1'b1; init_visited = 1'b1; ref_index = 9'd0; num_images = 9'd3;
        @(posedge clk); #1;
        start = 1'b0; init_visited = 1'b0;
        cyc = 1;
        while (cyc < 15) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_best_index", int'(best_index), 0);
        chk("mrst_best_dist", int'(best_dist), 0);
        chk("mrst_none_left", int'(none_left), 0);
        chk("mrst_dist_A", int'(dist_A), 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("mrst_no_done", ndone, 0);
        run_search(1'b0, 0, 3, cyc, rd);
        check_result("post_rst", cyc, 1, 7, 0, 31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
